// File: rtl/sap_machine_p.sv
// sap_machine_p: parametrised SAP-style accumulator CPU. Unified RAM, A/B/IR/PC/MAR,
// adder/subtractor with C/Z flags, micro-sequenced fetch/execute, RAM preload while
// in reset or halted, a stalling IN instruction and a ready/valid OUT port.
module sap_machine_p #(
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = DATA_W - 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

  typedef enum logic [2:0] {F0, F1, X0, X1, X2, HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_JNC = 4'h9, OP_JNZ = 4'hA, OP_IN  = 4'hD,
    OP_OUT = 4'hE, OP_HLT = 4'hF
  } op_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] a_q, b_q, ir_q, out_data_q;
  logic              c_q, z_q, out_valid_q, halted_q;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] ram_rd, alu_b;
  logic [DATA_W:0]   alu_full;
  logic              sta_we, prog_ok;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign ram_rd  = mem_q[mar_q];
  assign sta_we  = (state_q == X1) && (opcode == OP_STA);
  assign prog_ok = prog_we && (reset || halted_q);

  assign in_ready  = !reset && (state_q == X0) && (opcode == OP_IN) && in_valid;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign dbg_pc    = pc_q;

  // Adder/subtractor: subtraction as A + ~B + 1, carry out doubles as no-borrow.
  always_comb begin
    alu_b    = (opcode == OP_SUB) ? ~b_q : b_q;
    alu_full = {1'b0, a_q} + {1'b0, alu_b} + (DATA_W+1)'(opcode == OP_SUB);
  end

  // RAM write port: CPU store wins over the external programming port.
  always_ff @(posedge clk) begin
    if (sta_we) begin
      mem_q[mar_q] <= a_q;
    end else if (prog_ok) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Fetch/execute sequencer with all architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= F0;
      pc_q        <= '0;
      mar_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        F0: begin
          mar_q   <= pc_q;
          state_q <= F1;
        end
        F1: begin
          ir_q    <= ram_rd;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= X0;
        end
        X0: begin
          state_q <= F0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_q   <= operand;
              state_q <= X1;
            end
            OP_LDI: a_q <= DATA_W'(operand);
            OP_JMP: pc_q <= operand;
            OP_JC:  if (c_q)  pc_q <= operand;
            OP_JZ:  if (z_q)  pc_q <= operand;
            OP_JNC: if (!c_q) pc_q <= operand;
            OP_JNZ: if (!z_q) pc_q <= operand;
            OP_IN: begin
              if (in_valid) a_q <= in_data;
              else          state_q <= X0;
            end
            OP_OUT: begin
              out_data_q  <= a_q;
              out_valid_q <= 1'b1;
              state_q     <= X1;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end
            default: ;
          endcase
        end
        X1: begin
          state_q <= F0;
          case (opcode)
            OP_LDA: a_q <= ram_rd;
            OP_ADD, OP_SUB: begin
              b_q     <= ram_rd;
              state_q <= X2;
            end
            OP_OUT: begin
              if (out_ready) out_valid_q <= 1'b0;
              else           state_q <= X1;
            end
            default: ;
          endcase
        end
        X2: begin
          a_q     <= alu_full[DATA_W-1:0];
          c_q     <= alu_full[DATA_W];
          z_q     <= (alu_full[DATA_W-1:0] == '0);
          state_q <= F0;
        end
        HALT: ;
        default: state_q <= F0;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_machine_p.sv
// tb_sap_machine_p: directed and randomized checks of sap_machine_p against an
// instruction-level reference model (8-bit instance) plus literal checks (12-bit instance).
module tb_sap_machine_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       reset, prog_we, in_valid, in_ready, out_valid, out_ready, halted;
  logic [3:0] prog_addr, dbg_pc;
  logic [7:0] prog_data, in_data, out_data;

  // 12-bit instance
  logic        rst2, we2, inv2, inr2, outv2, outr2, halt2;
  logic [7:0]  addr2, pc2;
  logic [11:0] pdata2, ind2, outd2;

  sap_machine_p #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .halted(halted), .dbg_pc(dbg_pc)
  );

  sap_machine_p #(.DATA_W(12)) dut12 (
    .clk(clk), .reset(rst2), .prog_we(we2), .prog_addr(addr2),
    .prog_data(pdata2), .in_data(ind2), .in_valid(inv2),
    .in_ready(inr2), .out_data(outd2), .out_valid(outv2),
    .out_ready(outr2), .halted(halt2), .dbg_pc(pc2)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (8-bit machine) ----------------
  // m_k counts cycles inside the current instruction: 0,1 fetch; 2.. execute.
  logic [7:0]  m_mem [16];
  logic [7:0]  m_a = '0, m_ir = '0, m_outd = '0;
  logic [3:0]  m_pc = '0;
  logic        m_c = 1'b0, m_z = 1'b0, m_outv = 1'b0, m_halt = 1'b0;
  int unsigned m_k = 0;
  bit          seen_rst = 1'b0;
  logic [7:0]  got_q [$];
  logic [11:0] got2 [$];
  int unsigned in_pulses = 0;

  function automatic void model_step();
    logic [3:0] op, arg;
    int unsigned s;
    op  = m_ir[7:4];
    arg = m_ir[3:0];
    if (reset || m_halt) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (reset) begin
        m_pc = '0; m_a = '0; m_ir = '0; m_outd = '0;
        m_c = 1'b0; m_z = 1'b0; m_outv = 1'b0; m_halt = 1'b0; m_k = 0;
      end
      return;
    end
    case (m_k)
      0: m_k = 1;
      1: begin m_ir = m_mem[m_pc]; m_pc = m_pc + 4'd1; m_k = 2; end
      2: begin
        m_k = 0;
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4: m_k = 3;
          4'h5: m_a = {4'h0, arg};
          4'h6: m_pc = arg;
          4'h7: if (m_c)  m_pc = arg;
          4'h8: if (m_z)  m_pc = arg;
          4'h9: if (!m_c) m_pc = arg;
          4'hA: if (!m_z) m_pc = arg;
          4'hD: if (in_valid) m_a = in_data; else m_k = 2;
          4'hE: begin m_outd = m_a; m_outv = 1'b1; m_k = 3; end
          4'hF: m_halt = 1'b1;
          default: ;
        endcase
      end
      3: begin
        m_k = 0;
        case (op)
          4'h1: m_a = m_mem[arg];
          4'h4: m_mem[arg] = m_a;
          4'h2, 4'h3: m_k = 4;
          4'hE: if (out_ready) m_outv = 1'b0; else m_k = 3;
          default: ;
        endcase
      end
      default: begin
        if (op == 4'h2) begin
          s   = int'(m_a) + int'(m_mem[arg]);
          m_c = (s > 255);
          m_a = m_a + m_mem[arg];
        end else begin
          m_c = (m_a >= m_mem[arg]);
          m_a = m_a - m_mem[arg];
        end
        m_z = (m_a == 8'h00);
        m_k = 0;
      end
    endcase
  endfunction

  always @(posedge clk) if (reset) seen_rst <= 1'b1;

  // Single compare process: outputs vs model every cycle, then advance the model.
  always @(negedge clk) begin
    if (seen_rst) begin
      chk("pc", 32'(dbg_pc), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("out_data", 32'(out_data), 32'(m_outd));
      chk("in_ready", 32'(in_ready),
          32'(!reset && !m_halt && m_k == 2 && m_ir[7:4] == 4'hD && in_valid));
      if (out_valid && out_ready && !reset) got_q.push_back(out_data);
      if (in_ready) in_pulses++;
    end
    model_step();
  end

  always @(negedge clk) begin
    if (outv2 && outr2 && !rst2) got2.push_back(outd2);
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] img [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    foreach (img[i]) img[i] = 8'h00;
  endtask

  // Idle reset cycle first, then program all 16 words under reset, then release.
  task automatic load();
    reset = 1'b1; prog_we = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      step();
    end
    prog_we = 1'b0;
    got_q.delete();
    in_pulses = 0;
    reset = 1'b0;
  endtask

  task automatic run_halt(input string nm, input int unsigned budget, output int unsigned n);
    n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(halted), 32'd1);
  endtask

  function automatic logic [31:0] qat(input int unsigned i);
    return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
  endfunction

  task automatic poke2(input logic [7:0] a, input logic [11:0] d);
    we2 = 1'b1; addr2 = a; pdata2 = d;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned n;
    int unsigned fa, fb, cnt;
    logic [7:0] w;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rst2 = 1'b1; we2 = 1'b0; addr2 = '0; pdata2 = '0; ind2 = '0; inv2 = 1'b0; outr2 = 1'b1;
    step();

    // T1: LDI 7, OUT, HLT
    clear_img();
    img[0] = 8'h57; img[1] = 8'hE0; img[2] = 8'hF0;
    out_ready = 1'b1;
    load();
    run_halt("t1_halt", 100, n);
    chk("t1_cycles", n, 32'd10);
    chk("t1_nxfer", got_q.size(), 32'd1);
    chk("t1_val", qat(0), 32'd7);

    // T2: 200+100 -> 44 C=1; 44-44 -> 0 Z=1 C=1; JZ and JC taken
    clear_img();
    img[0] = 8'h1D; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'h4F; img[4] = 8'h3F;
    img[5] = 8'h87; img[6] = 8'hF0; img[7] = 8'h79; img[8] = 8'hF0; img[9] = 8'hE0;
    img[10] = 8'hF0; img[13] = 8'hC8; img[14] = 8'h64;
    load();
    run_halt("t2_halt", 200, n);
    chk("t2_nxfer", got_q.size(), 32'd2);
    chk("t2_sum", qat(0), 32'd44);
    chk("t2_diff", qat(1), 32'd0);
    chk("t2_pc", 32'(dbg_pc), 32'd11);

    // T3: OUT stalled 10 cycles
    clear_img();
    img[0] = 8'h59; img[1] = 8'hE0; img[2] = 8'hF0;
    out_ready = 1'b0;
    load();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("t3_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", 32'({out_valid, out_data, dbg_pc}), 32'({1'b1, 8'h09, 4'h2}));
      step();
    end
    out_ready = 1'b1;
    run_halt("t3_halt", 50, n);
    chk("t3_nxfer", got_q.size(), 32'd1);
    chk("t3_val", qat(0), 32'd9);

    // T4: IN waits 5 cycles, flags preserved across IN
    clear_img();
    img[0] = 8'h50; img[1] = 8'h3F; img[2] = 8'hD0; img[3] = 8'h85;
    img[4] = 8'hF0; img[5] = 8'hE0; img[6] = 8'hF0;
    in_valid = 1'b0;
    load();
    repeat (15) step();
    chk("t4_pc_wait", 32'(dbg_pc), 32'd3);
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("t4_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_ready_drop", 32'(in_ready), 32'd0);
    run_halt("t4_halt", 50, n);
    chk("t4_pulses", in_pulses, 32'd1);
    chk("t4_nxfer", got_q.size(), 32'd1);
    chk("t4_val", qat(0), 32'h5A);

    // T5: prog_we ignored while running, honoured while halted, reset reruns
    clear_img();
    img[0] = 8'h13; img[1] = 8'hE0; img[2] = 8'hF0; img[3] = 8'h21;
    load();
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'h77;
    step(); step();
    prog_we = 1'b0;
    run_halt("t5_halt1", 50, n);
    chk("t5_first", qat(0), 32'h21);
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'h33;
    step();
    prog_we = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_halt_clr", 32'(halted), 32'd0);
    run_halt("t5_halt2", 50, n);
    chk("t5_nxfer", got_q.size(), 32'd2);
    chk("t5_second", qat(1), 32'h33);

    // Reset during an OUT stall: no transfer in the reset cycle
    clear_img();
    img[0] = 8'h59; img[1] = 8'hE0; img[2] = 8'hF0;
    out_ready = 1'b0;
    load();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    reset = 1'b1; out_ready = 1'b1;
    step();
    chk("rst_outv", 32'(out_valid), 32'd0);
    reset = 1'b0;
    run_halt("rst_out_halt", 50, n);
    chk("rst_out_nxfer", got_q.size(), 32'd1);

    // Reset during an IN wait
    clear_img();
    img[0] = 8'hD0; img[1] = 8'hF0;
    in_valid = 1'b0;
    load();
    repeat (4) step();
    reset = 1'b1; in_valid = 1'b1;
    #1;
    chk("rst_inready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_in_pc", 32'(dbg_pc), 32'd0);

    // Randomized programs and handshakes, checked every cycle by the model
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        w = 8'($urandom);
        if (w[7:4] == 4'hF && $urandom_range(0, 3) != 0) w[7:4] = 4'h5;
        img[i] = w;
      end
      load();
      for (int c = 0; c < 300; c++) begin
        in_valid  = ($urandom_range(0, 3) == 0);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        prog_we   = ($urandom_range(0, 7) == 0);
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
        reset     = ($urandom_range(0, 99) == 0) && !(m_k == 3 && m_ir[7:4] == 4'h4);
        step();
      end
      reset = 1'b0; prog_we = 1'b0;
    end
    reset = 1'b1; prog_we = 1'b0;

    // 12-bit: PC wrap past address 255
    poke2(8'h00, 12'h6FF);
    poke2(8'hFF, 12'h000);
    we2 = 1'b0;
    step();
    rst2 = 1'b0;
    n = 0;
    while (pc2 != 8'hFF && n < 20) begin step(); n++; end
    chk("w_pc255", 32'(pc2), 32'hFF);
    step();
    chk("w_f0", 32'(pc2), 32'hFF);
    step();
    chk("w_wrap", 32'(pc2), 32'h00);
    step(); step(); step();
    chk("w_fetch0", 32'(pc2), 32'h01);
    step();
    chk("w_refetch", 32'(pc2), 32'hFF);

    // 12-bit: Fibonacci program
    rst2 = 1'b1;
    step();
    poke2(8'd0, 12'h180);  poke2(8'd1, 12'hE00);  poke2(8'd2, 12'h281);
    poke2(8'd3, 12'h482);  poke2(8'd4, 12'h181);  poke2(8'd5, 12'h480);
    poke2(8'd6, 12'h182);  poke2(8'd7, 12'h481);  poke2(8'd8, 12'h180);
    poke2(8'd9, 12'h383);  poke2(8'd10, 12'h80C); poke2(8'd11, 12'h600);
    poke2(8'd12, 12'hF00); poke2(8'h80, 12'h000); poke2(8'h81, 12'h001);
    poke2(8'h82, 12'h000); poke2(8'h83, 12'd377);
    we2 = 1'b0;
    got2.delete();
    rst2 = 1'b0;
    n = 0;
    while (!halt2 && n < 3000) begin step(); n++; end
    chk("fib_halt", 32'(halt2), 32'd1);
    chk("fib_count", got2.size(), 32'd14);
    fa = 0; fb = 1; cnt = 0;
    while (fa <= 233) begin
      chk("fib_val", (cnt < got2.size()) ? 32'(got2[cnt]) : 32'hDEAD, fa);
      cnt++;
      fb = fa + fb;
      fa = fb - fa;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
